// File: rtl/lsu_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_stage_pkg
//  Purpose  : Shared types and constants for the load/store stage: FSM state
//             encoding, RISC-V load/store funct3 codes, and the bit positions
//             of the execute-stage payload and write-back bundle fields.
//  Revision : 1.0 - initial release
// ============================================================================
package lsu_stage_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CAPTURE  = 3'd1,
        S_REQ      = 3'd2,
        S_WAIT_RSP = 3'd3,
        S_OUT      = 3'd4
    } lsu_state_t;

    // Loads and stores share funct3 encodings; each set is used by its own path
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int EXU_W          = 109;
    localparam int EXU_ADDR_LSB   = 77;
    localparam int EXU_RS2_LSB    = 45;
    localparam int EXU_MEM_REN    = 44;
    localparam int EXU_MEM_WEN    = 43;
    localparam int EXU_F3_LSB     = 40;
    localparam int EXU_RD_LSB     = 35;
    localparam int EXU_REG_WEN    = 34;
    localparam int EXU_WB_SEL_LSB = 32;
    localparam int EXU_CSR_LSB    = 0;

    localparam int LSU_W          = 105;
    localparam int LSU_ADDR_LSB   = 73;
    localparam int LSU_LOAD_LSB   = 41;
    localparam int LSU_CSR_LSB    = 9;
    localparam int LSU_RD_LSB     = 4;
    localparam int LSU_REG_WEN    = 3;
    localparam int LSU_WB_SEL_LSB = 1;
    localparam int LSU_ERR        = 0;

    // Decoded execute-stage payload
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        ren;
        logic        wen;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic        reg_wen;
        logic [1:0]  wb_sel;
        logic [31:0] csr;
    } exu_pkt_t;

endpackage : lsu_stage_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_align
//  Purpose  : Combinational byte-lane logic for the load/store stage.
//  Ports    : addr_lo_i  - address bits [1:0]
//             funct3_i   - access size / signedness
//             ren_i      - load access
//             wen_i      - store access (dominates ren_i)
//             rs2_i      - raw store data
//             rdata_i    - raw read word from memory
//             wdata_o    - lane-shifted store data
//             wmask_o    - byte enables (0 unless storing)
//             load_o     - extracted and extended load value
//             misalign_o - access crosses its natural alignment
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_stage_pkg::*;
(
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    input  logic        ren_i,
    input  logic        wen_i,
    input  logic [31:0] rs2_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] load_o,
    output logic        misalign_o
);

    logic [4:0]  shift;
    logic [31:0] lane;

    assign shift = {addr_lo_i, 3'b000};
    assign lane  = rdata_i >> shift;

    always_comb begin
        wdata_o = '0;
        wmask_o = '0;
        if (wen_i) begin
            case (funct3_i)
                SB: begin
                    wmask_o = 4'b0001 << addr_lo_i;
                    wdata_o = rs2_i << shift;
                end
                SH: begin
                    wmask_o = 4'b0011 << addr_lo_i;
                    wdata_o = rs2_i << shift;
                end
                SW: begin
                    wmask_o = 4'b1111;
                    wdata_o = rs2_i;
                end
                // Undefined store sizes behave as a word store
                default: begin
                    wmask_o = 4'b1111;
                    wdata_o = rs2_i;
                end
            endcase
        end
    end

    always_comb begin
        case (funct3_i)
            LB:      load_o = {{24{lane[7]}}, lane[7:0]};
            LH:      load_o = {{16{lane[15]}}, lane[15:0]};
            LBU:     load_o = {24'h0, lane[7:0]};
            LHU:     load_o = {16'h0, lane[15:0]};
            LW:      load_o = lane;
            // Undefined load sizes behave as lw (lane == rdata when aligned)
            default: load_o = lane;
        endcase
    end

    always_comb begin
        misalign_o = 1'b0;
        if (wen_i) begin
            case (funct3_i)
                SB:      misalign_o = 1'b0;
                SH:      misalign_o = addr_lo_i[0];
                default: misalign_o = |addr_lo_i;
            endcase
        end else if (ren_i) begin
            case (funct3_i)
                LB, LBU: misalign_o = 1'b0;
                LH, LHU: misalign_o = addr_lo_i[0];
                default: misalign_o = |addr_lo_i;
            endcase
        end
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_stage
//  Purpose  : Load/store stage of the multi-cycle core. Accepts one
//             instruction from execute, performs at most one data-memory
//             access, and hands a packed bundle to write-back.
//  Ports    : clk, rst (async, active-low)
//             exu_valid/exu_data/lsu_ready      - execute-side handshake
//             lsu_valid/lsu_data/wbu_ready      - write-back handshake
//             mem_req_valid/mem_req_ready       - memory request handshake
//             mem_addr/mem_wen/mem_wdata/mem_wmask - request fields
//             mem_rsp_valid/mem_rdata           - memory response
//  Revision : 1.0 - initial release
// ============================================================================
module lsu_stage
    import lsu_stage_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               exu_valid,
    input  logic [EXU_W-1:0]   exu_data,
    output logic               lsu_ready,
    output logic               lsu_valid,
    output logic [LSU_W-1:0]   lsu_data,
    input  logic               wbu_ready,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [WIDTH-1:0]   mem_addr,
    output logic               mem_wen,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [3:0]         mem_wmask,
    input  logic               mem_rsp_valid,
    input  logic [WIDTH-1:0]   mem_rdata
);

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    lsu_state_t       state_q, state_d;
    exu_pkt_t         pkt_q, pkt_d, pkt_in, pkt_sel;
    logic [31:0]      load_q, load_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] al_wdata, al_load;
    logic [3:0]  al_wmask;
    logic        al_misalign;

    always_comb begin
        pkt_in.addr    = exu_data[EXU_ADDR_LSB +: 32];
        pkt_in.rs2     = exu_data[EXU_RS2_LSB +: 32];
        pkt_in.ren     = exu_data[EXU_MEM_REN];
        pkt_in.wen     = exu_data[EXU_MEM_WEN];
        pkt_in.funct3  = exu_data[EXU_F3_LSB +: 3];
        pkt_in.rd      = exu_data[EXU_RD_LSB +: 5];
        pkt_in.reg_wen = exu_data[EXU_REG_WEN];
        pkt_in.wb_sel  = exu_data[EXU_WB_SEL_LSB +: 2];
        pkt_in.csr     = exu_data[EXU_CSR_LSB +: 32];
    end

    // Misalignment must be known while the payload is still on exu_data;
    // afterwards the aligner works from the latched copy.
    assign pkt_sel = (state_q == S_CAPTURE) ? pkt_in : pkt_q;

    lsu_align u_align (
        .addr_lo_i  (pkt_sel.addr[1:0]),
        .funct3_i   (pkt_sel.funct3),
        .ren_i      (pkt_sel.ren),
        .wen_i      (pkt_sel.wen),
        .rs2_i      (pkt_sel.rs2),
        .rdata_i    (mem_rdata),
        .wdata_o    (al_wdata),
        .wmask_o    (al_wmask),
        .load_o     (al_load),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pkt_q   <= '0;
            load_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pkt_q   <= pkt_d;
            load_q  <= load_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pkt_d   = pkt_q;
        load_d  = load_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (exu_valid) state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                pkt_d  = pkt_in;
                load_d = '0;
                err_d  = 1'b0;
                if (al_misalign) begin
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else if (pkt_in.ren || pkt_in.wen) begin
                    state_d = S_REQ;
                end else begin
                    state_d = S_OUT;
                end
            end
            S_REQ: begin
                if (mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                // A response in the final counted cycle still wins
                if (mem_rsp_valid) begin
                    load_d  = pkt_q.wen ? 32'h0 : al_load;
                    state_d = S_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    load_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (wbu_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign lsu_ready     = (state_q == S_IDLE);
    assign lsu_valid     = (state_q == S_OUT);
    assign mem_req_valid = (state_q == S_REQ);
    assign mem_addr      = {pkt_q.addr[31:2], 2'b00};
    assign mem_wen       = pkt_q.wen;
    assign mem_wdata     = al_wdata;
    assign mem_wmask     = al_wmask;

    assign lsu_data = {pkt_q.addr, load_q, pkt_q.csr, pkt_q.rd,
                       pkt_q.reg_wen, pkt_q.wb_sel, err_q};

endmodule : lsu_stage
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_stage
//  Purpose  : Directed self-checking bench for lsu_stage (TIMEOUT = 8).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_stage;

    logic           clk = 1'b0;
    logic           rst;
    logic           exu_valid;
    logic [108:0]   exu_data;
    logic           lsu_ready;
    logic           lsu_valid;
    logic [104:0]   lsu_data;
    logic           wbu_ready;
    logic           mem_req_valid;
    logic           mem_req_ready;
    logic [31:0]    mem_addr;
    logic           mem_wen;
    logic [31:0]    mem_wdata;
    logic [3:0]     mem_wmask;
    logic           mem_rsp_valid;
    logic [31:0]    mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu_stage #(.WIDTH(32), .TIMEOUT(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .exu_valid     (exu_valid),
        .exu_data      (exu_data),
        .lsu_ready     (lsu_ready),
        .lsu_valid     (lsu_valid),
        .lsu_data      (lsu_data),
        .wbu_ready     (wbu_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_wen       (mem_wen),
        .mem_wdata     (mem_wdata),
        .mem_wmask     (mem_wmask),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    function automatic logic [108:0] mk(input logic [31:0] a, input logic [31:0] rs2,
                                        input logic ren, input logic wen,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic rw, input logic [1:0] wb,
                                        input logic [31:0] csr);
        return {a, rs2, ren, wen, f3, rd, rw, wb, csr};
    endfunction

    function automatic logic [104:0] wbb(input logic [31:0] a, input logic [31:0] ld,
                                         input logic [31:0] csr, input logic [4:0] rd,
                                         input logic rw, input logic [1:0] wb,
                                         input logic err);
        return {a, ld, csr, rd, rw, wb, err};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transfer one payload; exu_data stays on the bus through capture
    task automatic send(input logic [108:0] d);
        exu_data  = d;
        exu_valid = 1'b1;
        tick();
        exu_valid = 1'b0;
    endtask

    // Full memory transaction ending with the bundle presented (S_OUT)
    task automatic mem_txn(input logic [108:0] d, input logic [31:0] rd_word);
        send(d);
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rd_word;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic retire();
        wbu_ready = 1'b1;
        tick();
        wbu_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; exu_valid = 1'b0; exu_data = '0; wbu_ready = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        repeat (2) tick();
        chk("rst_ready", lsu_ready, 1'b1);
        chk("rst_valid", lsu_valid, 1'b0);
        chk("rst_req",   mem_req_valid, 1'b0);
        chk("rst_data",  lsu_data, 105'h0);
        @(negedge clk) rst = 1'b1;
        tick();

        // ALU op without memory access
        send(mk(32'h1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd3, 1'b1, 2'b00, 32'hA5));
        chk("alu_cap_ready", lsu_ready, 1'b0);
        chk("alu_cap_valid", lsu_valid, 1'b0);
        tick();
        chk("alu_valid", lsu_valid, 1'b1);
        chk("alu_noreq", mem_req_valid, 1'b0);
        chk("alu_data",  lsu_data, wbb(32'h1234, 32'h0, 32'hA5, 5'd3, 1'b1, 2'b00, 1'b0));
        retire();
        chk("alu_idle", lsu_ready, 1'b1);

        // sb to byte 3, request held for two stalled cycles
        send(mk(32'h8000_0003, 32'h0000_00EF, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0, 2'b00, 32'h0));
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sb_req",   mem_req_valid, 1'b1);
            chk("sb_addr",  mem_addr, 32'h8000_0000);
            chk("sb_wmask", mem_wmask, 4'b1000);
            chk("sb_wdata", mem_wdata, 32'hEF00_0000);
            chk("sb_wen",   mem_wen, 1'b1);
            if (i < 2) tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        chk("sb_req_drop", mem_req_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h1234_5678;
        tick();
        mem_rsp_valid = 1'b0;
        chk("sb_data", lsu_data, wbb(32'h8000_0003, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 1'b0));
        retire();

        // sh to halfword 2
        send(mk(32'h0000_0042, 32'h1234_BEEF, 1'b0, 1'b1, 3'b001, 5'd0, 1'b0, 2'b00, 32'h0));
        tick();
        chk("sh_addr",  mem_addr, 32'h0000_0040);
        chk("sh_wmask", mem_wmask, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hBEEF_0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        retire();

        // lh / lhu at halfword 2
        send(mk(32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b001, 5'd5, 1'b1, 2'b01, 32'h0));
        tick();
        chk("lh_addr",  mem_addr, 32'h0000_0100);
        chk("lh_wen",   mem_wen, 1'b0);
        chk("lh_wmask", mem_wmask, 4'b0000);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h8001_0000;
        tick();
        mem_rsp_valid = 1'b0;
        chk("lh_data", lsu_data, wbb(32'h0000_0102, 32'hFFFF_8001, 32'h0, 5'd5, 1'b1, 2'b01, 1'b0));
        retire();

        mem_txn(mk(32'h0000_0102, 32'h0, 1'b1, 1'b0, 3'b101, 5'd6, 1'b1, 2'b01, 32'h0), 32'h8001_0000);
        chk("lhu_data", lsu_data, wbb(32'h0000_0102, 32'h0000_8001, 32'h0, 5'd6, 1'b1, 2'b01, 1'b0));
        retire();

        // lb at byte 1: 0x80 sign-extends
        mem_txn(mk(32'h0000_0011, 32'h0, 1'b1, 1'b0, 3'b000, 5'd2, 1'b1, 2'b01, 32'h0), 32'h0000_8000);
        chk("lb_data", lsu_data, wbb(32'h0000_0011, 32'hFFFF_FF80, 32'h0, 5'd2, 1'b1, 2'b01, 1'b0));
        retire();

        // Misaligned lw: no request, err, bundle held under back-pressure
        send(mk(32'h0000_0201, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1, 2'b01, 32'h55));
        chk("mis_cap_req", mem_req_valid, 1'b0);
        tick();
        chk("mis_req",   mem_req_valid, 1'b0);
        chk("mis_valid", lsu_valid, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("mis_data",  lsu_data, wbb(32'h0000_0201, 32'h0, 32'h55, 5'd7, 1'b1, 2'b01, 1'b1));
            chk("mis_ready", lsu_ready, 1'b0);
            tick();
        end
        chk("mis_hold_valid", lsu_valid, 1'b1);
        retire();

        // lw timeout: 8 cycles waiting
        send(mk(32'h0000_0300, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1, 2'b01, 32'h0));
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_waiting", lsu_valid, 1'b0);
        end
        tick();
        chk("to_valid", lsu_valid, 1'b1);
        chk("to_data",  lsu_data, wbb(32'h0000_0300, 32'h0, 32'h0, 5'd8, 1'b1, 2'b01, 1'b1));
        retire();

        // Response in the timeout cycle wins
        send(mk(32'h0000_0400, 32'h0, 1'b1, 1'b0, 3'b010, 5'd9, 1'b1, 2'b01, 32'h0));
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (7) tick();
        chk("race_wait", lsu_valid, 1'b0);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hDEAD_BEEF;
        tick();
        mem_rsp_valid = 1'b0;
        chk("race_data", lsu_data, wbb(32'h0000_0400, 32'hDEAD_BEEF, 32'h0, 5'd9, 1'b1, 2'b01, 1'b0));
        retire();

        // Asynchronous reset while waiting for a response
        send(mk(32'h0000_0500, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1, 2'b01, 32'h77));
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (2) tick();
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", lsu_ready, 1'b1);
        chk("arst_valid", lsu_valid, 1'b0);
        chk("arst_req",   mem_req_valid, 1'b0);
        chk("arst_data",  lsu_data, 105'h0);
        @(negedge clk) rst = 1'b1;
        tick();
        chk("arst_rel_ready", lsu_ready, 1'b1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFE_F00D;
        tick();
        mem_rsp_valid = 1'b0;
        chk("late_rsp_valid", lsu_valid, 1'b0);
        tick();
        chk("late_rsp_valid2", lsu_valid, 1'b0);
        chk("late_rsp_ready",  lsu_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lsu_stage
`default_nettype wire
